// File: rtl/clock24_pkg.sv
// Shared constants, BCD digit type and BCD increment helper for the 24-hour clock.
// Used by time_count (optional DAYPULSE output under CLOCK24_DAYPULSE_EN) and cnt60.
package clock24_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  // Two-digit BCD +1 that wraps to 00 after reaching max_val.
  function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max_val);
    bcd_digit_t tens;
    bcd_digit_t ones;
    tens = val[7:4];
    ones = val[3:0];
    if (val == max_val) begin
      bcd_inc = 8'h00;
    end else if (ones == 4'd9) begin
      bcd_inc = {tens + 4'd1, 4'd0};
    end else begin
      bcd_inc = {tens, ones + 4'd1};
    end
  endfunction

endpackage

// File: rtl/cnt60.sv
// BCD mod-60 counter with increment, synchronous clear and combinational carry-out.
// The carry is only raised on an increment that wraps, and never on a clear.
module cnt60
  import clock24_pkg::*;
#(
  parameter logic [7:0] MAX_VAL = SEC_MAX
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_inc,
  input  logic       i_clr,
  output logic [7:0] o_cnt,
  output logic       o_carry
);

  logic [7:0] r_cnt;
  logic       w_carry;

  // Count register: clear wins over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'h00;
    end else if (i_clr) begin
      r_cnt <= 8'h00;
    end else if (i_inc) begin
      r_cnt <= bcd_inc(r_cnt, MAX_VAL);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Wrap detection feeding the next stage in the same cycle.
  always_comb begin
    w_carry = 1'b0;
    if (i_inc && !i_clr && (r_cnt == MAX_VAL)) begin
      w_carry = 1'b1;
    end else begin
      w_carry = 1'b0;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_carry = w_carry;

endmodule

// File: rtl/time_count.sv
// 24-hour BCD time-of-day counter (HH:MM:SS) with manual minute/hour set inputs.
// Define CLOCK24_DAYPULSE_EN to add the DAYPULSE output (one CLK on 23:59:59 rollover).
module time_count
  import clock24_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       SIG1HZ,
  input  logic       SECCLR,
  input  logic       MININC,
  input  logic       HOURINC,
  output logic [7:0] SEC,
  output logic [7:0] MIN,
`ifdef CLOCK24_DAYPULSE_EN
  output logic [7:0] HOUR,
  output logic       DAYPULSE
`else
  output logic [7:0] HOUR
`endif
);

  logic [7:0] w_sec;
  logic [7:0] w_min;
  logic       w_sec_carry;
  logic       w_min_wrap;
  logic       w_min_carry;
  logic       w_hour_inc;
  logic [7:0] r_hour;

  cnt60 #(.MAX_VAL(SEC_MAX)) u_sec (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_inc   (SIG1HZ),
    .i_clr   (SECCLR),
    .o_cnt   (w_sec),
    .o_carry (w_sec_carry)
  );

  cnt60 #(.MAX_VAL(MIN_MAX)) u_min (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_inc   (MININC | w_sec_carry),
    .i_clr   (1'b0),
    .o_cnt   (w_min),
    .o_carry (w_min_wrap)
  );

  // A manual minute wrap must not ripple into the hours.
  assign w_min_carry = w_min_wrap & w_sec_carry;
  assign w_hour_inc  = HOURINC | w_min_carry;

  // Hour register, 00..23.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hour <= 8'h00;
    end else if (w_hour_inc) begin
      r_hour <= bcd_inc(r_hour, HOUR_MAX);
    end else begin
      r_hour <= r_hour;
    end
  end

`ifdef CLOCK24_DAYPULSE_EN
  logic r_daypulse;

  // Day pulse only for a carry-chain rollover, not for HOURINC.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_daypulse <= 1'b0;
    end else if (w_min_carry && (r_hour == HOUR_MAX)) begin
      r_daypulse <= 1'b1;
    end else begin
      r_daypulse <= 1'b0;
    end
  end

  assign DAYPULSE = r_daypulse;
`endif

  assign SEC  = w_sec;
  assign MIN  = w_min;
  assign HOUR = r_hour;

endmodule

// File: tb/tb_time_count.sv
// Scoreboard bench for time_count: stimulus pushes model results, a monitor pops and compares.
// Build with CLOCK24_DAYPULSE_EN defined to also check DAYPULSE.
module tb_time_count;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SIG1HZ;
  logic       SECCLR;
  logic       MININC;
  logic       HOURINC;
  logic [7:0] SEC;
  logic [7:0] MIN;
  logic [7:0] HOUR;
`ifdef CLOCK24_DAYPULSE_EN
  logic       DAYPULSE;
`endif

  typedef struct {
    int h;
    int m;
    int s;
    bit day;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mh = 0;
  int   mm = 0;
  int   ms = 0;

  time_count dut (
    .CLK      (CLK),
    .RST      (RST),
    .SIG1HZ   (SIG1HZ),
    .SECCLR   (SECCLR),
    .MININC   (MININC),
    .HOURINC  (HOURINC),
    .SEC      (SEC),
    .MIN      (MIN),
`ifdef CLOCK24_DAYPULSE_EN
    .HOUR     (HOUR),
    .DAYPULSE (DAYPULSE)
`else
    .HOUR     (HOUR)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  // Monitor: compare the DUT against the oldest expected entry after each edge.
  always @(posedge CLK) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_tests++;
      if (SEC !== to_bcd(mon_e.s) || MIN !== to_bcd(mon_e.m) || HOUR !== to_bcd(mon_e.h)
`ifdef CLOCK24_DAYPULSE_EN
          || DAYPULSE !== mon_e.day
`endif
         ) begin
        n_fail++;
        $display("FAIL scoreboard t=%0t got %h:%h:%h want %h:%h:%h", $time, HOUR, MIN, SEC,
                 to_bcd(mon_e.h), to_bcd(mon_e.m), to_bcd(mon_e.s));
`ifdef CLOCK24_DAYPULSE_EN
        $display("     daypulse got %0b want %0b", DAYPULSE, mon_e.day);
`endif
      end
    end
  end

  task automatic check_zero(input string nm);
    n_tests++;
    if (SEC !== 8'h00 || MIN !== 8'h00 || HOUR !== 8'h00
`ifdef CLOCK24_DAYPULSE_EN
        || DAYPULSE !== 1'b0
`endif
       ) begin
      n_fail++;
      $display("FAIL %s got %h:%h:%h want 00:00:00", nm, HOUR, MIN, SEC);
    end
  endtask

  // One request cycle: drive at negedge, step the reference model, push the result.
  task automatic tick(input bit sig, input bit clr, input bit mi, input bit hi);
    bit   sc;
    bit   mc;
    bit   day;
    exp_t e;
    @(negedge CLK);
    SIG1HZ  = sig;
    SECCLR  = clr;
    MININC  = mi;
    HOURINC = hi;
    sc = sig && !clr && (ms == 59);
    if (clr) ms = 0;
    else if (sig) ms = (ms + 1) % 60;
    mc = 1'b0;
    if (mi || sc) begin
      mc = sc && (mm == 59);
      mm = (mm + 1) % 60;
    end
    day = 1'b0;
    if (hi || mc) begin
      day = mc && (mh == 23);
      mh = (mh + 1) % 24;
    end
    e.h = mh;
    e.m = mm;
    e.s = ms;
    e.day = day;
    q.push_back(e);
    @(posedge CLK);
    #2;
    SIG1HZ  = 1'b0;
    SECCLR  = 1'b0;
    MININC  = 1'b0;
    HOURINC = 1'b0;
  endtask

  // Asynchronous reset away from the clock edge; requests during reset are ignored.
  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_zero("async_reset");
    SIG1HZ  = 1'b1;
    MININC  = 1'b1;
    HOURINC = 1'b1;
    @(posedge CLK);
    #1;
    check_zero("reset_hold");
    SIG1HZ  = 1'b0;
    MININC  = 1'b0;
    HOURINC = 1'b0;
    q.delete();
    mh = 0;
    mm = 0;
    ms = 0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (i < h || i < m || i < s) tick(i < s, 1'b0, i < m, i < h);
    end
  endtask

  task automatic rand_tick();
    tick($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
         $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
  endtask

  initial begin
    RST = 1'b1;
    SIG1HZ = 1'b0;
    SECCLR = 1'b0;
    MININC = 1'b0;
    HOURINC = 1'b0;
    #1;
    RST = 1'b0;
    #1;
    check_zero("reset_state");
    @(negedge CLK);
    RST = 1'b1;

    set_time(12, 34, 56);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();

    set_time(23, 59, 59);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);

    set_time(0, 10, 59);
    tick(1'b1, 1'b1, 1'b0, 1'b0);

    set_time(7, 59, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);

    set_time(10, 59, 59);
    tick(1'b1, 1'b0, 1'b1, 1'b1);

    set_time(9, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_time(19, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    set_time(23, 0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    set_time(5, 5, 5);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (5) tick(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      set_time($urandom_range(20, 23), $urandom_range(57, 59), $urandom_range(55, 59));
      repeat (25) rand_tick();
    end

    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else rand_tick();
    end

    @(negedge CLK);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain got %0d pending want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/time_count.md
TIME_COUNT -- requirements
Module: time_count

Interface
REQ-001 SHALL have port CLK, input, 1: sole clock, all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1: reset, asynchronous and active-low.
REQ-003 SHALL have port SIG1HZ, input, 1: one-CLK-wide 1 Hz count-enable pulse.
REQ-004 SHALL have port SECCLR, input, 1: seconds-clear request from the mode state machine, sampled every CLK.
REQ-005 SHALL have port MININC, input, 1: minute-increment request, sampled every CLK, one-CLK-wide pulse per press (upstream debounce/one-shot).
REQ-006 SHALL have port HOURINC, input, 1: hour-increment request, same pulse rules as MININC.
REQ-007 SHALL have port SEC, output, 8: seconds, BCD {tens[7:4], ones[3:0]}, registered.
REQ-008 SHALL have port MIN, output, 8: minutes, BCD, registered.
REQ-009 SHALL have port HOUR, output, 8: hours, BCD, registered, 24-hour format.

Function
REQ-010 SHALL hold SEC in 00..59, MIN in 00..59, HOUR in 00..23; every BCD nibble 0..9 at all times.
REQ-011 SHALL increment SEC by 1 on a CLK edge where SIG1HZ=1 and SECCLR=0; ones 9 wraps to 0 with tens+1; 59 wraps to 00 and asserts an internal seconds carry that cycle.
REQ-012 SHALL set SEC to 00 on a CLK edge where SECCLR=1, regardless of SIG1HZ, with no seconds carry generated.
REQ-013 SHALL increment MIN by exactly 1 on a CLK edge where MININC=1 or the seconds carry is set; both in the same cycle still give +1 only.
REQ-014 SHALL wrap MIN 59->00; the minute carry SHALL be generated only by a seconds-carry-driven wrap, never by MININC.
REQ-015 SHALL increment HOUR by exactly 1 on a CLK edge where HOURINC=1 or the minute carry is set; both together give +1 only.
REQ-016 SHALL wrap HOUR 23->00 (ones 3 with tens 2 -> 00); 09->10 and 19->20 via normal BCD carry.
REQ-017 SHALL have latency of one CLK from a sampled request to the updated output; each output changes at most once per CLK.
REQ-018 SHALL treat a request held high for N cycles as N increments; no edge detection inside this block.
REQ-019 SHALL allow SECCLR, MININC and HOURINC in the same cycle, each acting independently per REQ-012/013/015.

Reset
REQ-020 SHALL force SEC=00, MIN=00, HOUR=00 immediately on RST low, independent of CLK.
REQ-021 SHALL resume counting on the first CLK edge after RST deasserts; a SIG1HZ pulse coincident with reset release is ignored.
REQ-022 SHALL abort any in-progress carry chain on reset mid-operation; no partial update survives.

Configuration
REQ-023 SHALL support macro CLOCK24_DAYPULSE_EN.
REQ-024 With CLOCK24_DAYPULSE_EN defined: extra output DAYPULSE, 1 bit, registered, reset 0, high for exactly one CLK when HOUR wraps 23->00 through the carry chain (not through HOURINC).
REQ-025 Without CLOCK24_DAYPULSE_EN: no DAYPULSE port, no related logic; all other behaviour identical.

Structure
REQ-026 SHALL place constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MAX=8'h23 and the BCD digit type in shared package clock24_pkg.
REQ-027 SHALL use one sub-module cnt60: BCD mod-60 counter with inc, clr, carry-out, instantiated for seconds and minutes; the hour counter is inline.

Verification
REQ-028 Reset: RST low mid-count at 12:34:56 -> outputs 00:00:00 before next CLK edge.
REQ-029 Rollover: preload 23:59:59, one SIG1HZ -> 00:00:00 next cycle; with macro, DAYPULSE=1 for one cycle.
REQ-030 Clear priority: SEC=59, MIN=10, SECCLR=1 and SIG1HZ=1 same cycle -> SEC=00, MIN stays 10.
REQ-031 Manual minute: MIN=59, HOUR=07, MININC pulse -> MIN=00, HOUR stays 07.
REQ-032 Coincident: 10:59:59, SIG1HZ=1 with MININC=1 and HOURINC=1 -> 11:00:00.
REQ-033 Hour BCD: HOUR=09 then 19 then 23, HOURINC pulse each -> 10, 20, 00; no DAYPULSE.
